// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and its inverse (deconvolution) partner.
package fir_pkg;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 2 * DATA_W;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_inv_state_t;

    // Default tap set, common to the forward FIR and the inverse filter (monic: tap 0 is 1).
    localparam int DEFAULT_ORDER = 10;
    localparam int DEFAULT_COEFFS [DEFAULT_ORDER] = '{1, 3, 2, 1, -3, 1, -3, -5, 6, 6};

endpackage

// File: rtl/fir_mac_unit.sv
// Combinational signed multiply-subtract: acc_next = acc - coeff * sample.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int ACC_W  = 2 * DATA_W
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [31:0]       coeff,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [ACC_W-1:0]  acc_next
);

    logic signed [ACC_W-1:0] product;

    // Sign-extend both operands to the accumulator width before multiplying.
    always_comb begin
        product  = ACC_W'(coeff) * ACC_W'(sample);
        acc_next = acc - product;
    end

endmodule

// File: rtl/fir_inverse_filter.sv
// Inverse of a monic direct-form FIR: x[n] = y[n] - sum_{k>=1} A[k]*x[n-k],
// evaluated with one shared MAC, one tap per cycle, valid/ready on both sides.
module fir_inverse_filter
    import fir_pkg::*;
#(
    parameter int ORDER              = DEFAULT_ORDER,
    parameter int DATA_W             = fir_pkg::DATA_W,
    parameter int A_COEFFS [ORDER]   = DEFAULT_COEFFS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int ACC_W  = 2 * DATA_W;
    localparam int K_W    = $clog2(ORDER) + 1;
    localparam int HIST_N = (ORDER > 1) ? ORDER - 1 : 1;
    localparam logic [K_W-1:0] LAST_TAP = K_W'(ORDER - 1);

    if (A_COEFFS[0] != 1) begin : g_monic_check
        $error("fir_inverse_filter: A_COEFFS[0] must be 1");
    end

    fir_inv_state_t           state, state_next;
    logic signed [DATA_W-1:0] hist [HIST_N];
    logic signed [ACC_W-1:0]  acc, acc_next;
    logic [K_W-1:0]           k;
    logic signed [31:0]       coeff;
    logic signed [DATA_W-1:0] tap_sample;
    logic                     accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign accept    = in_ready && in_valid && !flush;

    fir_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .acc      (acc),
        .coeff    (coeff),
        .sample   (tap_sample),
        .acc_next (acc_next)
    );

    // Select coefficient A[k] and history sample x[n-k] for the current tap.
    always_comb begin
        coeff      = '0;
        tap_sample = '0;
        for (int unsigned i = 1; i < ORDER; i++) begin
            if (k == K_W'(i)) begin
                coeff      = A_COEFFS[i];
                tap_sample = hist[i-1];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> MAC -> OUT -> IDLE (MAC skipped for a single-tap filter).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (ORDER == 1) state_next = OUT;
                    else            state_next = MAC;
                end
            end
            MAC:     if (k == LAST_TAP) state_next = OUT;
            OUT:     if (out_ready)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: accumulator, tap counter, output register and recovered-sample history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            k        <= '0;
            out_data <= '0;
            for (int unsigned i = 0; i < HIST_N; i++) hist[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        for (int unsigned i = 0; i < HIST_N; i++) hist[i] <= '0;
                    end else if (in_valid) begin
                        acc <= ACC_W'($signed(in_data));
                        k   <= K_W'(1);
                        if (ORDER == 1) out_data <= in_data;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + K_W'(1);
                    if (k == LAST_TAP) out_data <= acc_next[DATA_W-1:0];
                end
                OUT: begin
                    if (out_ready) begin
                        hist[0] <= out_data;
                        for (int unsigned i = 1; i < HIST_N; i++) hist[i] <= hist[i-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
